// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit connection: op request, flush, status and HI/LO export.
// The EX stage drives the master side; the sequencer implements the slave side.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers.
// Operands are reduced to magnitudes on entry; signs are reapplied in a single FIX cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic en);
        return en ? ((~v) + (2*WIDTH)'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return cond_neg(v, is_signed & v[WIDTH-1]);
    endfunction

    // Control state (reset)
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Datapath state (no reset; only meaningful while busy)
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;

    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] fix_result;

    always_comb begin
        signed_op = ~bus.op[0];

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, opnd_q};
        div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        fix_result = is_div_q
            ? {cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q), cond_neg(acc_q[WIDTH-1:0], neg_res_q)}
            : cond_neg_wide(acc_q, neg_res_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, magnitude(bus.rt_val, signed_op)};
                            opnd_d    = magnitude(bus.rs_val, signed_op);
                            neg_res_d = signed_op & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = '0;
                            state_d   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (bus.rt_val == '0) begin
                                // Divide by zero: fixed result, no sign correction in FIX
                                acc_d     = {bus.rs_val, {WIDTH{1'b1}}};
                                neg_res_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = FIX;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, magnitude(bus.rs_val, signed_op)};
                                opnd_d    = magnitude(bus.rt_val, signed_op);
                                neg_res_d = signed_op & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                                neg_rem_d = signed_op & bus.rs_val[WIDTH-1];
                                state_d   = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = fix_result;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including an MTHI/MTLO or FIX write this cycle
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opnd_q    <= opnd_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        is_div_q  <= is_div_d;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed MUL/DIV/MT vectors, flush and async reset.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MTHI  = 3'd4;
    localparam logic [2:0] MTLO  = 3'd5;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_len;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();
    muldiv_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    bit   stim_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int exp_edges, input int exp_busy, input string name);
        int edges;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.busy_len = exp_busy; e.name = name;
        sb_q.push_back(e);
        start_op(op, rs, rt);
        edges = 1;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_latency"}, edges, exp_edges);
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] val,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
        start_op(op, val, 32'h0);
        check({name, "_hilo"}, {bus.hi, bus.lo}, {ehi, elo});
        check({name, "_busy_done"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.flush  = 1'b0;

        fork
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
                check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
                rst_n = 1'b1;
                @(posedge clk);
                #1;

                do_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 34, 33, "mult_neg");
                do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 33, "multu_max");
                do_op(MULT,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 34, 33, "mult_m1");
                do_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, "div_m7_2");
                do_op(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 33, "div_7_m2");
                do_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 33, "divu_100_7");
                do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 33, "div_min_m1");
                do_op(DIV,   32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 2,  1,  "div_by0_s");
                do_op(DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 2,  1,  "divu_by0");

                // Reserved opcode leaves everything untouched
                start_op(3'b110, 32'h1111_1111, 32'h2222_2222);
                check("rsvd_op_hilo", {bus.hi, bus.lo}, {32'h0000_1234, 32'hFFFF_FFFF});
                check("rsvd_op_busy", {63'd0, bus.busy}, 64'd0);

                do_mt(MTHI, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, "mthi");

                // Flush a MULT mid-iteration
                start_op(MULT, 32'd3, 32'd4);
                repeat (10) @(posedge clk);
                #1;
                check("flush_busy_before", {63'd0, bus.busy}, 64'd1);
                bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
                busy_run = 0;
                check("flush_busy_after", {63'd0, bus.busy}, 64'd0);
                check("flush_hilo", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'hFFFF_FFFF});

                // MTLO together with flush is dropped
                bus.flush = 1'b1;
                start_op(MTLO, 32'd5, 32'd0);
                bus.flush = 1'b0;
                check("flush_mtlo_lo", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFF});
                repeat (40) @(posedge clk);
                #1;
                do_mt(MTLO, 32'd5, 32'hA5A5_A5A5, 32'd5, "mtlo");

                // Async reset in the middle of a DIV
                start_op(DIV, 32'd100, 32'd7);
                repeat (20) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check("areset_hilo", {bus.hi, bus.lo}, 64'd0);
                check("areset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
                busy_run = 0;
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                do_op(MULT, 32'd2, 32'd3, 32'd0, 32'd6, 34, 33, "mult_after_rst");
                repeat (3) @(posedge clk);
                stim_done = 1'b1;
            end
            begin : monitor
                exp_t e;
                while (!stim_done) begin
                    @(negedge clk);
                    if (bus.busy === 1'b1) busy_run++;
                    if (bus.done === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done",
                                     bus.hi, bus.lo);
                        end else begin
                            e = sb_q.pop_front();
                            check({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
                            check({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
                            check({e.name, "_busy_len"}, busy_run, e.busy_len);
                        end
                        busy_run = 0;
                    end
                end
            end
        join

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with HI/LO registers. Sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a 32-step radix-2 shift-add multiply or restoring divide. While the operation runs it holds `busy` so the hazard unit stalls any MFHI/MFLO or new HI/LO operation. HI/LO are exported for MFHI/MFLO forwarding.

## Interface
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid this cycle; sampled only when idle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  abort the in-flight op (exception or branch squash).
- `busy`  out  1  a MUL/DIV is in flight; the pipeline must stall HI/LO consumers and producers.
- `done`  out  1  one-cycle pulse; HI/LO were updated by a MUL/DIV on the previous edge.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset (async, `rst_n`=0):
  - state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration counter 0.
  - Reset mid-operation discards all work.
- IDLE behaviour with `start`=1:
  - MTHI/MTLO: write `rs_val` to `hi`/`lo` on that edge. Stay IDLE; no `busy`, no `done`.
  - MULT/MULTU:
    - Latch operands. For signed ops, take absolute values and record the result sign (sign(rs) XOR sign(rt)).
    - Go to MUL with counter 0.
  - DIV/DIVU with `rt_val` != 0:
    - Latch magnitudes, quotient sign (sign(rs) XOR sign(rt)) and remainder sign (sign(rs)).
    - Go to DIV.
  - DIV/DIVU with `rt_val` == 0: load result HI=`rs_val`, LO={WIDTH{1'b1}} directly and go to FIX, skipping iteration.
  - `op` 110/111: ignored.
- MUL: each cycle adds the multiplicand to the upper half of a 2·WIDTH accumulator when the current multiplier LSB is 1, then shifts right. After `WIDTH` iterations go to FIX.
- DIV: each cycle performs a restoring step: shift the remainder left by one, trial-subtract the divisor, set the quotient bit. After `WIDTH` iterations go to FIX.
- FIX:
  - Signed MUL: negate the 2·WIDTH product if the result sign is negative.
  - Signed DIV:
    - Negate the quotient if the quotient sign is negative.
    - Negate the remainder if the dividend was negative.
  - MUL writes {hi,lo} = product. DIV writes hi = remainder, lo = quotient.
  - Pulse `done`, return to IDLE.
- Arithmetic: all intermediate values are unsigned and modulo 2^(2·WIDTH). DIV 0x80000000 / -1 yields LO=0x80000000, HI=0 with no trap.
- `start` while not IDLE is ignored; the hazard unit guarantees this does not occur.
- `flush`:
  - Forces IDLE on the next edge from any state.
  - `hi`/`lo` keep their pre-op values and no `done` is issued.
  - `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is written, including MTHI/MTLO.
  - `flush` in FIX: the write is suppressed.

## Timing
- Start edge E0 (IDLE, `start`=1, MUL/DIV op):
  - `busy`=1 in the cycles after edges E0 through E32 (33 cycles: 32 iterations plus FIX).
  - Edge E33 writes `hi`/`lo`. `done`=1 and `busy`=0 in the cycle after E33.
  - Total latency: 34 edges from start to result visible.
- Divide by zero: `busy`=1 for one cycle (FIX); the result is written on E1 and `done` follows E1.
- MTHI/MTLO: result visible in the cycle after the start edge; `busy` stays 0.
- A new `start` may be presented in the `done` cycle (state is IDLE) and is accepted.
- All outputs are registered; no combinational path from inputs to `busy`/`done`/`hi`/`lo`.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> `done` 34 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA; `busy` high exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> `done` after 2 edges; hi=0x00001234, lo=0xFFFFFFFF.
- MTHI 0xA5A5A5A5, then MULT 3×4 with `flush` at iteration 10:
  - hi stays 0xA5A5A5A5; no `done`; `busy` drops the next cycle.
  - A following MTLO 5 in the same cycle as `flush` leaves lo unchanged.
- Async reset asserted mid-DIV (iteration 20) -> `busy`/`done`=0 and hi=lo=0 immediately. After release, MULT 2×3 completes normally with lo=6.
